char_writer: RTL
================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter NUM_COLS, default 80, character columns per screen (640 px / 8).
REQ-002 Parameter NUM_ROWS, default 60, character rows per screen (480 px / 8).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 char_val  input  1  producer asserts when char_data is valid.
REQ-006 char_rdy  output  1  block can accept a character this cycle.
REQ-007 char_data  input  8  ASCII code from the producer.
REQ-008 wen  output  1  character-memory write enable, registered.
REQ-009 waddr_row  output  $clog2(NUM_ROWS)  write row address, registered.
REQ-010 waddr_col  output  $clog2(NUM_COLS)  write column address, registered.
REQ-011 wdata  output  8  ASCII code to store, registered.
REQ-012 cursor_row / cursor_col  output  $clog2(NUM_ROWS) / $clog2(NUM_COLS)  current cursor position, registered.

Function
REQ-013 FSM states SHALL be CLEAR_ALL, IDLE and CLEAR_ROW; char_rdy SHALL be 1 only in IDLE.
REQ-014 Handshake: a character is accepted in any cycle with char_val && char_rdy; char_data is sampled only in that cycle.
REQ-015 Every write issued by the FSM in cycle T SHALL appear on wen/waddr_*/wdata in cycle T+1; wen SHALL be 0 in any cycle with no write.
REQ-016 Printable code (0x20-0x7E) accepted at cursor (r,c): issue write (r,c,code); cursor advances to (r,c+1).
REQ-017 Printable code at c = NUM_COLS-1: after the write, cursor moves to (next_row,0), and the FSM enters CLEAR_ROW.
REQ-018 next_row = r+1, or 0 when r = NUM_ROWS-1 (wrap, no scrolling).
REQ-019 0x0A (LF): no character write; cursor moves to (next_row,0); enter CLEAR_ROW.
REQ-020 0x0D (CR): no write; cursor moves to (r,0); remain IDLE.
REQ-021 0x08 (BS): if c>0, cursor moves to (r,c-1) and the block issues write (r,c-1,0x20); if c = 0, no move and no write.
REQ-022 0x0C (FF): cursor moves to (0,0); enter CLEAR_ALL.
REQ-023 Any other code SHALL be accepted and discarded, with no write and no cursor change.
REQ-024 CLEAR_ROW: for exactly NUM_COLS consecutive cycles, issue writes of 0x20 to (cursor_row, 0..NUM_COLS-1) in ascending order, then return to IDLE.
REQ-025 CLEAR_ROW timing: a printable code that wraps, accepted at T, writes at T+1, clears at T+2..T+NUM_COLS+1, and char_rdy=1 again at T+NUM_COLS+1.
REQ-026 CLEAR_ALL: for exactly NUM_ROWS*NUM_COLS consecutive cycles, issue writes of 0x20 in row-major order from (0,0) to (NUM_ROWS-1,NUM_COLS-1), then enter IDLE.
REQ-027 The cursor SHALL NOT change during CLEAR_ROW or CLEAR_ALL.
REQ-028 Column and row arithmetic SHALL never produce an out-of-range address for non-power-of-two NUM_COLS/NUM_ROWS.

Reset
REQ-029 While rst=1: wen=0, waddr_row=0, waddr_col=0, wdata=0, cursor=(0,0), char_rdy=0, state=CLEAR_ALL with clear counter 0.
REQ-030 The first cycle after rst deasserts SHALL issue the CLEAR_ALL write to (0,0), which is visible one cycle later.
REQ-031 rst asserted mid-CLEAR_ROW or mid-CLEAR_ALL SHALL abort the clear and restart CLEAR_ALL from (0,0).

Structure
REQ-032 A shared package (vga_ascii_pkg) SHALL hold ASCII control constants (BS, LF, FF, CR, SPACE), the printable range bounds, and the FSM state typedef.
REQ-033 One sub-module, char_cursor (cursor registers, advance/wrap/back logic), is natural; the clear counter and FSM remain in char_writer.

Verification (NUM_COLS=4, NUM_ROWS=3 unless stated)
REQ-034 Reset then idle: after rst falls, 12 writes of 0x20 to (0,0)..(2,3) on consecutive cycles; char_rdy=0 throughout, 1 on the following cycle; cursor=(0,0).
REQ-035 Send "AB" back-to-back: writes (0,0,0x41) and (0,1,0x42) on consecutive cycles; cursor=(0,2); char_rdy stays 1.
REQ-036 Send "WXYZ" from (0,0): four writes, then 4 space writes to row 1 cols 0..3, char_rdy=0 for 4 cycles; cursor=(1,0).
REQ-037 Cursor at (2,1), send LF: no character write, row 0 cleared, cursor=(0,0); then CR at (0,0): no write, cursor unchanged; BS at (0,0): no write.
REQ-038 Cursor at (1,2), send BS then 0x07: write (1,1,0x20), cursor=(1,1); 0x07 accepted with no write.
REQ-039 Mid-CLEAR_ALL (after the 5th write) assert rst for 1 cycle: clear restarts at (0,0), 12 full writes follow, char_val held high is not accepted until IDLE.

Source files
------------

// File: rtl/vga_ascii_pkg.sv
// Shared ASCII control codes, printable range and FSM/cursor encodings
// for the character-cell text writer.
package vga_ascii_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [7:0] PRINT_MIN   = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } wr_state_t;

    typedef enum logic [2:0] {
        CUR_HOLD    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_RETURN  = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_HOME    = 3'd5
    } cursor_cmd_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_MIN) && (code <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/char_cursor.sv
// Cursor position registers with advance, newline, return, backspace and
// home moves; rows wrap to the top instead of scrolling.
module char_cursor
    import vga_ascii_pkg::*;
#(
    parameter int NUM_COLS = 80,
    parameter int NUM_ROWS = 60
) (
    input  logic                        clk,
    input  logic                        rst,
    input  cursor_cmd_t                 cmd,
    output logic [$clog2(NUM_ROWS)-1:0] row,
    output logic [$clog2(NUM_COLS)-1:0] col,
    output logic                        at_eol,
    output logic [$clog2(NUM_COLS)-1:0] col_dec
);

    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

    logic [RW-1:0] next_row;

    // Explicit compare against the last index keeps non-power-of-two sizes in range.
    assign next_row = (row == ROW_LAST) ? '0 : row + 1'b1;
    assign at_eol   = (col == COL_LAST);
    assign col_dec  = col - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else begin
            case (cmd)
                CUR_ADVANCE: begin
                    if (at_eol) begin
                        col <= '0;
                        row <= next_row;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                CUR_NEWLINE: begin
                    col <= '0;
                    row <= next_row;
                end
                CUR_RETURN:  col <= '0;
                CUR_BACK: begin
                    if (col != '0) col <= col_dec;
                end
                CUR_HOME: begin
                    row <= '0;
                    col <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/char_writer.sv
// Accepts ASCII characters over a valid/ready handshake and turns them into
// registered character-memory writes, including row and screen clears.
module char_writer
    import vga_ascii_pkg::*;
#(
    parameter int NUM_COLS = 80,
    parameter int NUM_ROWS = 60
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        char_val,
    output logic                        char_rdy,
    input  logic [7:0]                  char_data,
    output logic                        wen,
    output logic [$clog2(NUM_ROWS)-1:0] waddr_row,
    output logic [$clog2(NUM_COLS)-1:0] waddr_col,
    output logic [7:0]                  wdata,
    output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
    output logic [$clog2(NUM_COLS)-1:0] cursor_col
);

    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

    wr_state_t     state, state_nx;
    logic [RW-1:0] clr_row, clr_row_nx;
    logic [CW-1:0] clr_col, clr_col_nx;

    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [7:0]    wr_data;

    cursor_cmd_t   cur_cmd;
    logic          at_eol;
    logic [CW-1:0] col_dec;

    char_cursor #(
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cur_cmd),
        .row     (cursor_row),
        .col     (cursor_col),
        .at_eol  (at_eol),
        .col_dec (col_dec)
    );

    assign char_rdy = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ALL;
            clr_row   <= '0;
            clr_col   <= '0;
            wen       <= 1'b0;
            waddr_row <= '0;
            waddr_col <= '0;
            wdata     <= '0;
        end else begin
            state     <= state_nx;
            clr_row   <= clr_row_nx;
            clr_col   <= clr_col_nx;
            wen       <= wr_en;
            waddr_row <= wr_row;
            waddr_col <= wr_col;
            wdata     <= wr_data;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_row_nx = clr_row;
        clr_col_nx = clr_col;
        wr_en      = 1'b0;
        wr_row     = cursor_row;
        wr_col     = cursor_col;
        wr_data    = ASCII_SPACE;
        cur_cmd    = CUR_HOLD;

        case (state)
            CLEAR_ALL: begin
                wr_en  = 1'b1;
                wr_row = clr_row;
                wr_col = clr_col;
                if (clr_col == COL_LAST) begin
                    clr_col_nx = '0;
                    if (clr_row == ROW_LAST) begin
                        clr_row_nx = '0;
                        state_nx   = IDLE;
                    end else begin
                        clr_row_nx = clr_row + 1'b1;
                    end
                end else begin
                    clr_col_nx = clr_col + 1'b1;
                end
            end

            // Cursor already sits on the row to blank; it holds until IDLE.
            CLEAR_ROW: begin
                wr_en  = 1'b1;
                wr_col = clr_col;
                if (clr_col == COL_LAST) begin
                    clr_col_nx = '0;
                    state_nx   = IDLE;
                end else begin
                    clr_col_nx = clr_col + 1'b1;
                end
            end

            IDLE: begin
                if (char_val) begin
                    if (is_printable(char_data)) begin
                        wr_en   = 1'b1;
                        wr_data = char_data;
                        cur_cmd = CUR_ADVANCE;
                        if (at_eol) state_nx = CLEAR_ROW;
                    end else begin
                        case (char_data)
                            ASCII_LF: begin
                                cur_cmd  = CUR_NEWLINE;
                                state_nx = CLEAR_ROW;
                            end
                            ASCII_CR: cur_cmd = CUR_RETURN;
                            ASCII_BS: begin
                                if (cursor_col != '0) begin
                                    wr_en   = 1'b1;
                                    wr_col  = col_dec;
                                    cur_cmd = CUR_BACK;
                                end
                            end
                            ASCII_FF: begin
                                cur_cmd  = CUR_HOME;
                                state_nx = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: state_nx = CLEAR_ALL;
        endcase
    end

endmodule
